// File: rtl/smpc_pad_scan_if.sv
// SMPC-side control, pin and result bundle for the pad scanner.
interface smpc_pad_scan_if;
  logic        START;
  logic [1:0]  PORT_EN;
  logic [1:0]  DIRECT;
  logic [6:0]  PDR1;
  logic [6:0]  PDR2;
  logic [6:0]  DDR1;
  logic [6:0]  DDR2;
  logic [6:0]  P1I;
  logic [6:0]  P2I;
  logic [6:0]  P1O;
  logic [6:0]  P2O;
  logic [6:0]  P1OE;
  logic [6:0]  P2OE;
  logic        BUSY;
  logic        DONE;
  logic [15:0] PAD1;
  logic [15:0] PAD2;
  logic [1:0]  PRESENT;

  modport master (
    output START, PORT_EN, DIRECT, PDR1, PDR2, DDR1, DDR2, P1I, P2I,
    input  P1O, P2O, P1OE, P2OE, BUSY, DONE, PAD1, PAD2, PRESENT
  );

  modport slave (
    input  START, PORT_EN, DIRECT, PDR1, PDR2, DDR1, DDR2, P1I, P2I,
    output P1O, P2O, P1OE, P2OE, BUSY, DONE, PAD1, PAD2, PRESENT
  );
endinterface

// File: rtl/smpc_pad_scan.sv
// Saturn pad scanner: drives TH/TR through 4 phases per port, builds active-low words; SMPC_PAD_ID_CHECK_EN adds the ID check.
// Latency: START to DONE = 4*N*(SETTLE+2)+1 CE ticks, N = eligible ports.
// Backpressure: none; START while BUSY is dropped, results held until the next DONE.
module smpc_pad_scan #(
  parameter int unsigned SETTLE = 8
) (
  input logic            CLK,
  input logic            RST_N,
  input logic            CE,
  smpc_pad_scan_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t      state;
  logic        port_sel;
  logic [1:0]  phase;
  logic [7:0]  settle_cnt;
  logic [1:0]  elig;
  logic [1:0]  aborted;
  logic [1:0]  thtr1;
  logic [1:0]  thtr2;
  logic [15:0] shadow1;
  logic [15:0] shadow2;
  logic [15:0] pad1_q;
  logic [15:0] pad2_q;
  logic [1:0]  present_q;
  logic        busy_q;
  logic        done_q;

  logic [1:0]  elig_now;
  logic [1:0]  id_ok;
  logic [1:0]  keep;
  logic        unused_pins;

  assign elig_now = bus.PORT_EN & ~bus.DIRECT;

`ifdef SMPC_PAD_ID_CHECK_EN
  assign id_ok = {shadow2[2:0] == 3'b100, shadow1[2:0] == 3'b100};
`else
  assign id_ok = 2'b11;
`endif

  // A port that went to direct mode at any point of the scan reports nothing.
  assign keep = elig & ~(aborted | bus.DIRECT) & id_ok;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      port_sel   <= 1'b0;
      phase      <= 2'd0;
      settle_cnt <= 8'd0;
      elig       <= 2'b00;
      aborted    <= 2'b00;
      thtr1      <= 2'b11;
      thtr2      <= 2'b11;
      shadow1    <= 16'hFFFF;
      shadow2    <= 16'hFFFF;
      pad1_q     <= 16'hFFFF;
      pad2_q     <= 16'hFFFF;
      present_q  <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (CE) begin
      done_q <= 1'b0;
      if (state != ST_IDLE) begin
        aborted <= aborted | bus.DIRECT;
      end
      case (state)
        ST_IDLE: begin
          // BUSY covers the DONE tick, so the tick after DONE only drops BUSY.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (bus.START) begin
            busy_q   <= 1'b1;
            elig     <= elig_now;
            aborted  <= 2'b00;
            shadow1  <= 16'hFFFF;
            shadow2  <= 16'hFFFF;
            phase    <= 2'd0;
            port_sel <= ~elig_now[0];
            state    <= (elig_now == 2'b00) ? ST_FINISH : ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (port_sel) thtr2 <= phase;
          else          thtr1 <= phase;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) state <= ST_SAMPLE;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          // Phase 0 lands in [15:12], phase 3 in [3:0].
          if (port_sel) shadow2[{~phase, 2'b00} +: 4] <= bus.P2I[3:0];
          else          shadow1[{~phase, 2'b00} +: 4] <= bus.P1I[3:0];
          if (phase != 2'd3) begin
            phase <= phase + 2'd1;
            state <= ST_DRIVE;
          end else if (!port_sel && elig[1]) begin
            port_sel <= 1'b1;
            phase    <= 2'd0;
            state    <= ST_DRIVE;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          pad1_q    <= keep[0] ? shadow1 : 16'hFFFF;
          pad2_q    <= keep[1] ? shadow2 : 16'hFFFF;
          present_q <= keep;
          done_q    <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.P1O     = bus.DIRECT[0] ? bus.PDR1 : {thtr1, 5'b00000};
  assign bus.P2O     = bus.DIRECT[1] ? bus.PDR2 : {thtr2, 5'b00000};
  assign bus.P1OE    = bus.DIRECT[0] ? bus.DDR1 : 7'h60;
  assign bus.P2OE    = bus.DIRECT[1] ? bus.DDR2 : 7'h60;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.PAD1    = pad1_q;
  assign bus.PAD2    = pad2_q;
  assign bus.PRESENT = present_q;

  assign unused_pins = ^{bus.P1I[6:4], bus.P2I[6:4]};

endmodule

// File: tb/tb_smpc_pad_scan.sv
// Bench for smpc_pad_scan: delayed-settling pad model on both ports, directed and randomized scans.
module tb_smpc_pad_scan;
  localparam int S = 8;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CE = 1'b0;

  smpc_pad_scan_if bus();

  smpc_pad_scan #(.SETTLE(S)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail = 0;
  int ce_ticks = 0;
  int done_events = 0;
  int t0 = 0;
  int stab [2];
  logic [1:0] last_thtr [2];
  logic [3:0] nib [2][4];
  bit ce_rand = 1'b0;

  // Pad answers with the complement until its select lines have been stable S CE ticks.
  always_comb begin
    bus.P1I = {3'b101, (stab[0] >= S) ? nib[0][bus.P1O[6:5]] : ~nib[0][bus.P1O[6:5]]};
    bus.P2I = {3'b010, (stab[1] >= S) ? nib[1][bus.P2O[6:5]] : ~nib[1][bus.P2O[6:5]]};
  end

  task automatic step();
    logic ce_edge;
    logic [1:0] cur;
    ce_edge = CE;
    @(posedge CLK);
    #1;
    if (ce_edge) begin
      ce_ticks++;
      if (bus.DONE) done_events++;
      for (int p = 0; p < 2; p++) begin
        cur = (p == 0) ? bus.P1O[6:5] : bus.P2O[6:5];
        if (cur != last_thtr[p]) begin
          stab[p] = 0;
          last_thtr[p] = cur;
        end else if (stab[p] < 1000) begin
          stab[p]++;
        end
      end
    end
    CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic do_start();
    CE = 1'b1;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    t0 = ce_ticks;
  endtask

  task automatic wait_done(input int budget, output int lat);
    int d0;
    d0 = done_events;
    lat = -1;
    for (int i = 0; i < budget && lat < 0; i++) begin
      step();
      if (done_events != d0) lat = ce_ticks - t0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && bus.BUSY; i++) step();
  endtask

  task automatic set_pads(input logic [15:0] w1, input logic [15:0] w2);
    for (int k = 0; k < 4; k++) begin
      nib[0][k] = w1[15 - 4*k -: 4];
      nib[1][k] = w2[15 - 4*k -: 4];
    end
  endtask

  function automatic logic [15:0] model_word(input int p);
    return {nib[p][0], nib[p][1], nib[p][2], nib[p][3]};
  endfunction

  function automatic bit model_present(input int p, input logic [1:0] en,
                                       input logic [1:0] dir, input logic [1:0] ab);
    bit ok;
    ok = en[p] && !dir[p] && !ab[p];
`ifdef SMPC_PAD_ID_CHECK_EN
    if (nib[p][3][2:0] != 3'b100) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic test_reset();
    n_tests++; if (bus.P1O !== 7'h60) begin n_fail++; $display("FAIL reset_p1o got %h want 60", bus.P1O); end
    n_tests++; if (bus.P2O !== 7'h60) begin n_fail++; $display("FAIL reset_p2o got %h want 60", bus.P2O); end
    n_tests++; if (bus.P1OE !== 7'h60) begin n_fail++; $display("FAIL reset_p1oe got %h want 60", bus.P1OE); end
    n_tests++; if (bus.P2OE !== 7'h60) begin n_fail++; $display("FAIL reset_p2oe got %h want 60", bus.P2OE); end
    n_tests++; if (bus.PAD1 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pad1 got %h want ffff", bus.PAD1); end
    n_tests++; if (bus.PAD2 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_pad2 got %h want ffff", bus.PAD2); end
    n_tests++; if (bus.PRESENT !== 2'b00) begin n_fail++; $display("FAIL reset_present got %b want 00", bus.PRESENT); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.BUSY); end
    n_tests++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.DONE); end
  endtask

  task automatic test_two_pads();
    int lat;
    set_pads(16'hFED4, 16'hFFFC);
    bus.PORT_EN = 2'b11;
    bus.DIRECT = 2'b00;
    do_start();
    n_tests++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL two_busy_start got %b want 1", bus.BUSY); end
    wait_done(300, lat);
    n_tests++; if (lat != 4*2*(S+2)+1) begin n_fail++; $display("FAIL two_latency got %0d want %0d", lat, 4*2*(S+2)+1); end
    n_tests++; if (bus.PAD1 !== 16'hFED4) begin n_fail++; $display("FAIL two_pad1 got %h want fed4", bus.PAD1); end
    n_tests++; if (bus.PAD2 !== 16'hFFFC) begin n_fail++; $display("FAIL two_pad2 got %h want fffc", bus.PAD2); end
    n_tests++; if (bus.PRESENT !== 2'b11) begin n_fail++; $display("FAIL two_present got %b want 11", bus.PRESENT); end
    n_tests++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL two_busy_at_done got %b want 1", bus.BUSY); end
    n_tests++; if (bus.P1O !== 7'h60) begin n_fail++; $display("FAIL two_p1o_left got %h want 60", bus.P1O); end
    step();
    n_tests++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL two_done_width got %b want 0", bus.DONE); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL two_busy_end got %b want 0", bus.BUSY); end
  endtask

  task automatic test_direct_mode();
    int lat;
    bus.PORT_EN = 2'b01;
    bus.DIRECT = 2'b01;
    bus.PDR1 = 7'h2A;
    bus.DDR1 = 7'h7F;
    #1;
    n_tests++; if (bus.P1O !== 7'h2A) begin n_fail++; $display("FAIL direct_p1o got %h want 2a", bus.P1O); end
    n_tests++; if (bus.P1OE !== 7'h7F) begin n_fail++; $display("FAIL direct_p1oe got %h want 7f", bus.P1OE); end
    do_start();
    wait_done(20, lat);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL direct_latency got %0d want 1", lat); end
    n_tests++; if (bus.PAD1 !== 16'hFFFF) begin n_fail++; $display("FAIL direct_pad1 got %h want ffff", bus.PAD1); end
    n_tests++; if (bus.PRESENT !== 2'b00) begin n_fail++; $display("FAIL direct_present got %b want 00", bus.PRESENT); end
    bus.DIRECT = 2'b00;
    wait_idle();
  endtask

  task automatic test_float();
    int lat;
    logic exp_p2;
`ifdef SMPC_PAD_ID_CHECK_EN
    exp_p2 = 1'b0;
`else
    exp_p2 = 1'b1;
`endif
    set_pads(16'hFED4, 16'hFFFF);
    bus.PORT_EN = 2'b11;
    do_start();
    wait_done(300, lat);
    n_tests++; if (bus.PAD2 !== 16'hFFFF) begin n_fail++; $display("FAIL float_pad2 got %h want ffff", bus.PAD2); end
    n_tests++; if (bus.PRESENT !== {exp_p2, 1'b1}) begin n_fail++; $display("FAIL float_present got %b want %b", bus.PRESENT, {exp_p2, 1'b1}); end
    wait_idle();
  endtask

  task automatic test_busy_start();
    int lat;
    int d0;
    int rel;
    set_pads(16'hFED4, 16'hFFFC);
    bus.PORT_EN = 2'b11;
    bus.PDR2 = 7'h15;
    bus.DDR2 = 7'h33;
    do_start();
    d0 = done_events;
    lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      rel = ce_ticks - t0;
      if (rel == 29) bus.START = 1'b1;
      if (rel == 49) begin
        bus.DIRECT = 2'b10;
        #1;
        n_tests++; if (bus.P2O !== 7'h15) begin n_fail++; $display("FAIL busy_p2o_direct got %h want 15", bus.P2O); end
        n_tests++; if (bus.P2OE !== 7'h33) begin n_fail++; $display("FAIL busy_p2oe_direct got %h want 33", bus.P2OE); end
      end
      step();
      bus.START = 1'b0;
      if (done_events != d0) lat = ce_ticks - t0;
    end
    n_tests++; if (lat != 4*2*(S+2)+1) begin n_fail++; $display("FAIL busy_latency got %0d want %0d", lat, 4*2*(S+2)+1); end
    n_tests++; if (bus.PAD1 !== 16'hFED4) begin n_fail++; $display("FAIL busy_pad1 got %h want fed4", bus.PAD1); end
    n_tests++; if (bus.PAD2 !== 16'hFFFF) begin n_fail++; $display("FAIL busy_pad2 got %h want ffff", bus.PAD2); end
    n_tests++; if (bus.PRESENT !== 2'b01) begin n_fail++; $display("FAIL busy_present got %b want 01", bus.PRESENT); end
    for (int i = 0; i < 120; i++) step();
    n_tests++; if (done_events - d0 != 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", done_events - d0); end
    bus.DIRECT = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    int d0;
    set_pads(16'h7BD4, 16'hEEEC);
    bus.PORT_EN = 2'b11;
    do_start();
    for (int i = 0; i < 20; i++) step();
    RST_N = 1'b0;
    #1;
    n_tests++; if (bus.P1O !== 7'h60) begin n_fail++; $display("FAIL rmid_p1o got %h want 60", bus.P1O); end
    n_tests++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", bus.BUSY); end
    n_tests++; if (bus.PAD1 !== 16'hFFFF) begin n_fail++; $display("FAIL rmid_pad1 got %h want ffff", bus.PAD1); end
    n_tests++; if (bus.PRESENT !== 2'b00) begin n_fail++; $display("FAIL rmid_present got %b want 00", bus.PRESENT); end
    d0 = done_events;
    step();
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) step();
    n_tests++; if (done_events != d0) begin n_fail++; $display("FAIL rmid_no_done got %0d want 0", done_events - d0); end
    do_start();
    wait_done(300, lat);
    n_tests++; if (lat != 4*2*(S+2)+1) begin n_fail++; $display("FAIL rmid_latency got %0d want %0d", lat, 4*2*(S+2)+1); end
    n_tests++; if (bus.PAD1 !== 16'h7BD4) begin n_fail++; $display("FAIL rmid_pad1_after got %h want 7bd4", bus.PAD1); end
    n_tests++; if (bus.PAD2 !== 16'hEEEC) begin n_fail++; $display("FAIL rmid_pad2_after got %h want eeec", bus.PAD2); end
    wait_idle();
  endtask

  task automatic test_random();
    logic [1:0] en, dir, ab, elig, exp_pres;
    logic [15:0] exp1, exp2;
    int n, exp_lat, lat, rp, rt, rel, d0;
    bit raise;
    ce_rand = 1'b1;
    for (int it = 0; it < 40; it++) begin
      en = 2'($urandom_range(0, 3));
      dir = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < 4; k++) nib[p][k] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) nib[0][3] = {nib[0][3][3], 3'b100};
      if ($urandom_range(0, 1) == 1) nib[1][3] = {nib[1][3][3], 3'b100};
      bus.PDR1 = 7'($urandom_range(0, 127));
      bus.PDR2 = 7'($urandom_range(0, 127));
      bus.PORT_EN = en;
      bus.DIRECT = dir;
      elig = en & ~dir;
      n = int'(elig[0]) + int'(elig[1]);
      exp_lat = 4 * n * (S + 2) + 1;
      raise = (n > 0) && ($urandom_range(0, 3) == 0);
      rp = $urandom_range(0, 1);
      rt = (exp_lat > 3) ? $urandom_range(1, exp_lat - 2) : 1;
      ab = 2'b00;
      if (raise) ab[rp] = 1'b1;
      do_start();
      d0 = done_events;
      lat = -1;
      for (int i = 0; i < 1000 && lat < 0; i++) begin
        rel = ce_ticks - t0;
        if (raise && rel == rt) bus.DIRECT[rp] = 1'b1;
        step();
        if (done_events != d0) lat = ce_ticks - t0;
      end
      exp_pres = {model_present(1, en, dir, ab), model_present(0, en, dir, ab)};
      exp1 = exp_pres[0] ? model_word(0) : 16'hFFFF;
      exp2 = exp_pres[1] ? model_word(1) : 16'hFFFF;
      n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, exp_lat); end
      n_tests++; if (bus.PAD1 !== exp1) begin n_fail++; $display("FAIL rand%0d_pad1 got %h want %h", it, bus.PAD1, exp1); end
      n_tests++; if (bus.PAD2 !== exp2) begin n_fail++; $display("FAIL rand%0d_pad2 got %h want %h", it, bus.PAD2, exp2); end
      n_tests++; if (bus.PRESENT !== exp_pres) begin n_fail++; $display("FAIL rand%0d_present got %b want %b", it, bus.PRESENT, exp_pres); end
      if (bus.DIRECT[1]) begin
        n_tests++; if (bus.P2O !== bus.PDR2) begin n_fail++; $display("FAIL rand%0d_p2o got %h want %h", it, bus.P2O, bus.PDR2); end
      end
      bus.DIRECT = 2'b00;
      wait_idle();
    end
    ce_rand = 1'b0;
    CE = 1'b1;
  endtask

  initial begin
    bus.START = 1'b0;
    bus.PORT_EN = 2'b00;
    bus.DIRECT = 2'b00;
    bus.PDR1 = 7'h00;
    bus.PDR2 = 7'h00;
    bus.DDR1 = 7'h00;
    bus.DDR2 = 7'h00;
    stab[0] = 0;
    stab[1] = 0;
    last_thtr[0] = 2'b11;
    last_thtr[1] = 2'b11;
    set_pads(16'hFFFF, 16'hFFFF);
    CE = 1'b1;
    RST_N = 1'b0;
    step();
    step();
    test_reset();
    RST_N = 1'b1;
    step();
    step();
    test_two_pads();
    test_direct_mode();
    test_float();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout no summary reached");
    $fatal(1, "timeout");
  end

endmodule
